// File: rtl/audio_event_scheduler.sv
// audio_event_scheduler
// Arbitrates game/keyboard sound requests and plays short jingles into the
// tone generator's prescale input. Time advances on startOfFrame ticks.
// Requests that arrive during playback are latched and served afterwards,
// lowest request index first, so nothing is lost.
module audio_event_scheduler #(
  parameter int unsigned NOTE_FRAMES = 2,  // frames each note sounds (1..255)
  parameter int unsigned GAP_FRAMES  = 1   // silent frames between notes (0..255)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       soundEnable,
  input  logic [5:0] audioRequest,
  output logic [9:0] preScaleValue,
  output logic       busy,
  output logic [2:0] activeEvent,
  output logic       eventDone
);

  localparam logic [7:0] NOTE_LOAD = NOTE_FRAMES[7:0];
  localparam logic [7:0] GAP_LOAD  = GAP_FRAMES[7:0];
  localparam logic [2:0] NO_EVENT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } stateT;

  stateT       stateReg;
  logic [5:0]  pendingReg;
  logic [5:0]  pendingNext;
  logic [7:0]  frameCnt;
  logic [1:0]  noteIdx;

  logic [5:0]  candidate;
  logic [5:0]  grantOneHot;
  logic [2:0]  grantIdx;
  logic        anyCandidate;
  logic        grantFire;
  logic [1:0]  nextIdx;
  logic        atLastNote;

  // Jingle note table: event index and note index to prescale value.
  function automatic logic [9:0] noteRom(input logic [2:0] ev, input logic [1:0] idx);
    logic [9:0] val;
    val = 10'h000;
    case ({ev, idx})
      {3'd0, 2'd0}: val = 10'h0DD;
      {3'd0, 2'd1}: val = 10'h0F9;
      {3'd0, 2'd2}: val = 10'h128;
      {3'd1, 2'd0}: val = 10'h117;
      {3'd2, 2'd0}: val = 10'h18B;
      {3'd3, 2'd0}: val = 10'h175;
      {3'd3, 2'd1}: val = 10'h128;
      {3'd3, 2'd2}: val = 10'h0F9;
      {3'd4, 2'd0}: val = 10'h14C;
      {3'd5, 2'd0}: val = 10'h128;
      default:      val = 10'h000;
    endcase
    return val;
  endfunction

  // Index of the final note of each jingle.
  function automatic logic [1:0] lastNoteIdx(input logic [2:0] ev);
    logic [1:0] idx;
    idx = 2'd0;
    case (ev)
      3'd0:    idx = 2'd2;
      3'd3:    idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Requests seen this clock count as candidates immediately, so an idle
  // scheduler answers on the very edge that samples the strobe.
  assign candidate    = pendingReg | audioRequest;
  assign anyCandidate = |candidate;
  assign grantFire    = soundEnable && (stateReg == IDLE) && anyCandidate;

  // Fixed-priority pick: a bit wins only if no lower-index bit is set.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : gPriority
      if (gi == 0) begin : gFirst
        assign grantOneHot[gi] = candidate[gi];
      end else begin : gRest
        assign grantOneHot[gi] = candidate[gi] & ~(|candidate[gi-1:0]);
      end
    end
  endgenerate

  // Convert the one-hot grant into the event index.
  always_comb begin
    grantIdx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (grantOneHot[i]) grantIdx = 3'(i);
    end
  end

  // Pending bits accumulate requests; the granted bit drops on its grant
  // edge even if it is re-requested then, and muting wipes everything.
  generate
    for (gi = 0; gi < 6; gi++) begin : gPending
      assign pendingNext[gi] = soundEnable & candidate[gi] & ~(grantFire & grantOneHot[gi]);
    end
  endgenerate

  assign nextIdx    = noteIdx + 2'd1;
  assign atLastNote = (noteIdx == lastNoteIdx(activeEvent));

  // Sequencer: grants in IDLE, times notes and gaps on frame ticks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg      <= IDLE;
      pendingReg    <= 6'd0;
      preScaleValue <= 10'd0;
      busy          <= 1'b0;
      activeEvent   <= NO_EVENT;
      eventDone     <= 1'b0;
      frameCnt      <= 8'd0;
      noteIdx       <= 2'd0;
    end else begin
      eventDone  <= 1'b0;
      pendingReg <= pendingNext;
      if (!soundEnable) begin
        stateReg      <= IDLE;
        preScaleValue <= 10'd0;
        busy          <= 1'b0;
        activeEvent   <= NO_EVENT;
        frameCnt      <= 8'd0;
        noteIdx       <= 2'd0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (anyCandidate) begin
              // A frame tick on this edge is deliberately not counted.
              stateReg      <= NOTE;
              busy          <= 1'b1;
              activeEvent   <= grantIdx;
              noteIdx       <= 2'd0;
              preScaleValue <= noteRom(grantIdx, 2'd0);
              frameCnt      <= NOTE_LOAD;
            end
          end
          NOTE: begin
            if (startOfFrame) begin
              if (frameCnt == 8'd1) begin
                if (atLastNote) begin
                  stateReg      <= IDLE;
                  preScaleValue <= 10'd0;
                  busy          <= 1'b0;
                  activeEvent   <= NO_EVENT;
                  eventDone     <= 1'b1;
                  frameCnt      <= 8'd0;
                  noteIdx       <= 2'd0;
                end else if (GAP_FRAMES > 0) begin
                  stateReg      <= GAP;
                  preScaleValue <= 10'd0;
                  frameCnt      <= GAP_LOAD;
                end else begin
                  noteIdx       <= nextIdx;
                  preScaleValue <= noteRom(activeEvent, nextIdx);
                  frameCnt      <= NOTE_LOAD;
                end
              end else begin
                frameCnt <= frameCnt - 8'd1;
              end
            end
          end
          GAP: begin
            if (startOfFrame) begin
              if (frameCnt == 8'd1) begin
                stateReg      <= NOTE;
                noteIdx       <= nextIdx;
                preScaleValue <= noteRom(activeEvent, nextIdx);
                frameCnt      <= NOTE_LOAD;
              end else begin
                frameCnt <= frameCnt - 8'd1;
              end
            end
          end
          default: begin
            stateReg      <= IDLE;
            preScaleValue <= 10'd0;
            busy          <= 1'b0;
            activeEvent   <= NO_EVENT;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/audio_event_scheduler.md
Name: audio_event_scheduler

Overview:
- Arbitrates game and keyboard sound events and sequences short multi-note jingles into the tone generator's 10-bit prescale input.
- Sits between the game-logic collision/key request strobes and the audio prescaler/tone generator.
- Advances time on startOfFrame ticks.
- Requests arriving while a jingle plays are latched and served afterwards in fixed priority order; nothing is dropped.

Parameters:
- NOTE_FRAMES, 2, frames each note sounds (1..255)
- GAP_FRAMES, 1, silent frames between notes of one jingle (0..255; 0 means back-to-back notes)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock frame tick
- soundEnable  in  1  0 = mute: abort playback, clear pending, ignore requests
- audioRequest  in  6  one-clock request strobes. Bit 0 holeCol, 1 ballToBallCol, 2 borderCol, 3 keyEnter, 4 keyX, 5 keyY.
- preScaleValue  out  10  prescale to tone generator; 0 = silence
- busy  out  1  1 while state is not IDLE
- activeEvent  out  3  index of the event playing; 3'd7 when idle
- eventDone  out  1  one-clock pulse when a jingle's last note ends

Behaviour:
- Reset (async): state IDLE, pending=0, preScaleValue=0, busy=0, activeEvent=7, eventDone=0, counters=0.
- Jingle ROM (note list, in order):
  - ev0: 0DD, 0F9, 128
  - ev1: 117
  - ev2: 18B
  - ev3: 175, 128, 0F9
  - ev4: 14C
  - ev5: 128
- Pending latch: each clock, pending |= audioRequest. The granted bit is cleared on its grant edge. A request and a grant of the same bit on the same edge leave that bit clear. Repeated requests for an already-pending event coalesce into one.
- Candidate vector is pending | audioRequest. Priority: lowest index wins.
- State IDLE:
  - If any candidate bit is set: grant it, load note 0 into preScaleValue, set activeEvent, load frameCnt=NOTE_FRAMES, go to NOTE.
  - Latency: a request sampled on edge t drives preScaleValue after edge t. This holds regardless of startOfFrame.
- State NOTE:
  - On each startOfFrame, frameCnt decrements.
  - On the tick where frameCnt==1, the note ends:
    - More notes and GAP_FRAMES>0: preScaleValue=0, frameCnt=GAP_FRAMES, go to GAP.
    - More notes and GAP_FRAMES==0: load next note, frameCnt=NOTE_FRAMES, stay in NOTE.
    - Last note: preScaleValue=0, activeEvent=7, eventDone=1 for this one clock, go to IDLE.
  - Each note therefore spans exactly NOTE_FRAMES startOfFrame ticks after its load.
- State GAP: on each startOfFrame, frameCnt decrements. On the tick where frameCnt==1, load the next note, set frameCnt=NOTE_FRAMES, go to NOTE.
- No preemption. A higher-priority request during playback only sets its pending bit. A request for the currently playing event sets pending and replays after.
- Back-to-back jingles: from IDLE, the next grant occurs on the clock after eventDone, so there is exactly one clock of silence.
- soundEnable=0 (any state):
  - Next edge: IDLE, pending=0, preScaleValue=0, activeEvent=7, eventDone=0.
  - Requests are ignored while low.
  - Playback resumes only on new requests after soundEnable returns to 1.
- startOfFrame coincident with a grant edge: the grant loads frameCnt, and that tick does not count toward the new note.
- Note index is 2 bits, and ROM lengths are 1..3.

Test Plan:
- Reset, then audioRequest=6'b000010 for one clock -> next edge preScaleValue=0x117, busy=1, activeEvent=1. After 2 startOfFrame ticks: preScaleValue=0, eventDone pulse, activeEvent=7.
- audioRequest=6'b000001 with GAP_FRAMES=1 -> sequence 0x0DD (2 ticks), 0 (1 tick), 0x0F9 (2), 0, 0x128 (2), then idle plus eventDone. Total 8 ticks.
- Same edge audioRequest=6'b101000 -> ev3 plays first (0x175…). ev5 then plays 0x128 one clock after ev3's eventDone.
- During ev3 playback, pulse bit 0 and bit 4, each twice -> ev3 completes uninterrupted, then ev0 plays once, then ev4 plays once.
- Mid-note of ev0, pull soundEnable low with bit 2 pending -> next edge preScaleValue=0, busy=0. After re-enable there is no playback until a new request arrives.
- GAP_FRAMES=0, ev3 -> 0x175, 0x128, 0x0F9 contiguous, 2 ticks each, with no zero between notes. Also assert resetN low mid-jingle -> outputs reset immediately, asynchronously.
